// File: rtl/cb_cfg_loader.sv
// Purpose : framed, checksummed config writer for a column of connection boxes.
// Latency : checksum byte accepted at edge k -> cfg_out/done (or err) update at edge k+2.
// Backpress: s_ready is a function of state only; low for the single COMMIT/ERROR cycle.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   s_data/s_valid/s_ready  byte stream, transfer on s_valid && s_ready
//   cfg_out        active config, CB i uses cfg_out[i*CFG_W +: CFG_W]
//   cfg_loaded     at least one frame committed since reset
//   done / err     one-cycle pulses on commit / checksum mismatch
//   busy           a frame is in progress
module cb_cfg_loader #(
   parameter int          CFG_W  = 10,
   parameter int          NUM_CB = 4,
   parameter logic [7:0]  SYNC   = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [CFG_W*NUM_CB-1:0]   cfg_out,
   output logic                      cfg_loaded,
   output logic                      done,
   output logic                      err,
   output logic                      busy
);

   localparam int TOTAL  = CFG_W * NUM_CB;
   localparam int NBYTES = (TOTAL + 7) / 8;
   localparam int SH_W   = 8 * NBYTES;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_PAYLOAD,
      ST_CHECK,
      ST_COMMIT,
      ST_ERROR
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         xor_q, xor_d;
   logic [SH_W-1:0]    shadow_q, shadow_d;
   logic [TOTAL-1:0]   cfg_q;
   logic               loaded_q;
   logic               done_q, err_q;
   logic               commit_pend_q, err_pend_q;
   logic               rdy_en_q;
   logic               accept;

   // Padding bits above TOTAL are checksummed but never reach cfg_out.
   if (SH_W > TOTAL) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^shadow_q[SH_W-1:TOTAL];
   end

   // rdy_en_q holds s_ready low while in reset and for the edge that releases it.
   assign s_ready = rdy_en_q && ((state_q == ST_SYNC) || (state_q == ST_PAYLOAD) ||
                                 (state_q == ST_CHECK));
   assign accept  = s_valid && s_ready;
   assign busy    = (state_q != ST_SYNC);

   assign cfg_out    = cfg_q;
   assign cfg_loaded = loaded_q;
   assign done       = done_q;
   assign err        = err_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      xor_d    = xor_q;
      shadow_d = shadow_q;
      case (state_q)
         ST_SYNC: begin
            if (accept && (s_data == SYNC)) begin
               state_d = ST_PAYLOAD;
               cnt_d   = '0;
               xor_d   = '0;
            end
         end
         ST_PAYLOAD: begin
            // SYNC-valued bytes are plain data here; no resync.
            if (accept) begin
               for (int j = 0; j < NBYTES; j++) begin
                  if (cnt_q == CNT_W'(j)) shadow_d[8*j +: 8] = s_data;
               end
               xor_d = xor_q ^ s_data;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NBYTES - 1)) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (accept) state_d = (s_data == xor_q) ? ST_COMMIT : ST_ERROR;
         end
         ST_COMMIT: state_d = ST_SYNC;
         ST_ERROR:  state_d = ST_SYNC;
         default:   state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_SYNC;
         cnt_q         <= '0;
         xor_q         <= '0;
         shadow_q      <= '0;
         cfg_q         <= '0;
         loaded_q      <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         commit_pend_q <= 1'b0;
         err_pend_q    <= 1'b0;
         rdy_en_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         xor_q         <= xor_d;
         shadow_q      <= shadow_d;
         rdy_en_q      <= 1'b1;
         // One pipeline stage after COMMIT/ERROR puts the result at k+2.
         // The shadow cannot change before then: the earliest next payload
         // byte lands at k+3.
         commit_pend_q <= (state_q == ST_COMMIT);
         err_pend_q    <= (state_q == ST_ERROR);
         done_q        <= commit_pend_q;
         err_q         <= err_pend_q;
         if (commit_pend_q) begin
            cfg_q    <= shadow_q[TOTAL-1:0];
            loaded_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cb_cfg_loader.sv
module tb_cb_cfg_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [39:0] a_cfg;
   logic [29:0] b_cfg;
   logic        a_loaded, b_loaded, a_done, b_done, a_err, b_err, a_busy, b_busy;

   cb_cfg_loader u_a (
      .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
      .cfg_out(a_cfg), .cfg_loaded(a_loaded), .done(a_done), .err(a_err), .busy(a_busy)
   );

   cb_cfg_loader #(.CFG_W(10), .NUM_CB(3), .SYNC(8'hA5)) u_b (
      .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .cfg_out(b_cfg), .cfg_loaded(b_loaded), .done(b_done), .err(b_err), .busy(b_busy)
   );

   // Currently addressed instance: 0 = 4 CBs (40 bits), 1 = 3 CBs (30 bits).
   logic        cur_sel = 1'b0;
   wire         cur_rdy    = cur_sel ? b_ready  : a_ready;
   wire         cur_done   = cur_sel ? b_done   : a_done;
   wire         cur_err    = cur_sel ? b_err    : a_err;
   wire         cur_busy   = cur_sel ? b_busy   : a_busy;
   wire         cur_loaded = cur_sel ? b_loaded : a_loaded;
   wire [63:0]  cur_cfg    = cur_sel ? {34'd0, b_cfg} : {24'd0, a_cfg};

   int          n_vec = 0;
   int          n_err = 0;

   // Reference model state, one entry per instance.
   logic [63:0] exp_cfg [2];
   logic        exp_loaded [2];
   logic [7:0]  fq [$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int nbytes_of(input logic sel);
      return sel ? 4 : 5;
   endfunction

   function automatic logic [63:0] mask_of(input logic sel);
      return sel ? ((64'd1 << 30) - 64'd1) : ((64'd1 << 40) - 64'd1);
   endfunction

   task automatic set_in(input logic v, input logic [7:0] d);
      if (cur_sel) begin
         b_valid = v; b_data = d;
      end else begin
         a_valid = v; a_data = d;
      end
   endtask

   // Entered and left at posedge+1. Holds the byte until it is taken.
   task automatic send_byte(input logic [7:0] d, input int idle);
      int n;
      set_in(1'b0, 8'h00);
      repeat (idle) begin
         @(posedge clk); #1;
      end
      set_in(1'b1, d);
      n = 0;
      forever begin
         @(negedge clk);
         if (cur_rdy) break;
         n++;
         if (n > 100) begin
            check_val("rdy_timeout", 64'd0, 64'd1);
            set_in(1'b0, 8'h00);
            return;
         end
      end
      @(posedge clk); #1;
      set_in(1'b0, 8'h00);
   endtask

   function automatic int idle_for(input int mode);
      if (mode == 1) return 2;
      if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      return 0;
   endfunction

   task automatic send_garbage(input logic [7:0] d);
      send_byte(d, 0);
      @(negedge clk);
      check_val("busy_garbage", {63'd0, cur_busy}, 64'd0);
      @(posedge clk); #1;
   endtask

   // Sends SYNC, the payload in fq and chk; then checks the outcome window.
   task automatic send_frame(input logic [7:0] chk, input int mode);
      logic [7:0]  x;
      logic [63:0] val;
      logic        good;
      int          s;
      int          errs;
      x   = 8'h00;
      val = 64'd0;
      foreach (fq[j]) begin
         x   = x ^ fq[j];
         val = val | (64'(fq[j]) << (8 * j));
      end
      good = (chk == x);
      s = int'(cur_sel);
      if (good) begin
         exp_cfg[s]    = val & mask_of(cur_sel);
         exp_loaded[s] = 1'b1;
      end
      send_byte(8'hA5, idle_for(mode));
      foreach (fq[j]) send_byte(fq[j], idle_for(mode));
      send_byte(chk, idle_for(mode));
      // Now just past accept edge k.
      errs = 0;
      @(negedge clk);
      check_val("rdy_gap", {63'd0, cur_rdy}, 64'd0);
      check_val("done_k1", {63'd0, cur_done}, 64'd0);
      errs += int'(cur_err);
      @(negedge clk);
      check_val("rdy_back", {63'd0, cur_rdy}, 64'd1);
      check_val("done_k2", {63'd0, cur_done}, 64'd0);
      errs += int'(cur_err);
      @(negedge clk);
      check_val("done_pulse", {63'd0, cur_done}, {63'd0, good});
      check_val("cfg_out", cur_cfg, exp_cfg[s]);
      check_val("cfg_loaded", {63'd0, cur_loaded}, {63'd0, exp_loaded[s]});
      errs += int'(cur_err);
      @(negedge clk);
      check_val("done_low", {63'd0, cur_done}, 64'd0);
      errs += int'(cur_err);
      check_val("err_count", 64'(errs), good ? 64'd0 : 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic load_fq5(input logic [39:0] v);
      logic [39:0] t;
      t = v;
      fq.delete();
      for (int j = 0; j < 5; j++) fq.push_back(t[8*j +: 8]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         exp_cfg[i]    = 64'd0;
         exp_loaded[i] = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] g;
      int         nb;
      a_valid = 1'b0; a_data = 8'h00;
      b_valid = 1'b0; b_data = 8'h00;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", {63'd0, a_ready}, 64'd0);
      check_val("rst_cfg", {24'd0, a_cfg}, 64'd0);
      check_val("rst_loaded", {63'd0, a_loaded}, 64'd0);
      check_val("rst_busy", {63'd0, a_busy}, 64'd0);
      check_val("rst_done_err", {62'd0, a_done, a_err}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("ready_pre_edge", {63'd0, a_ready}, 64'd0);
      @(negedge clk);
      check_val("ready_after_rst", {63'd0, a_ready}, 64'd1);
      @(posedge clk); #1;

      // Bad checksum right after reset: nothing commits.
      cur_sel = 1'b0;
      load_fq5(40'h8967452301);
      send_frame(8'h88, 0);
      // Good frame.
      send_frame(8'h89, 0);
      // Leading garbage, then a valid frame.
      send_garbage(8'h00);
      send_garbage(8'hFF);
      send_garbage(8'h3C);
      load_fq5(40'h1122334455);
      send_frame(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55, 0);
      // SYNC value inside the payload is data.
      load_fq5(40'h22A511A500);
      send_frame(8'h22 ^ 8'hA5 ^ 8'h11 ^ 8'hA5 ^ 8'h00, 0);
      // Stalled delivery of the first frame.
      load_fq5(40'h8967452301);
      send_frame(8'h89, 1);

      // Second instance: padding bits ignored.
      cur_sel = 1'b1;
      fq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(8'h00, 0);
      cur_sel = 1'b0;

      // Reset in the middle of a frame that follows a committed one.
      send_byte(8'hA5, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      rst = 1'b1;
      model_reset();
      #1;
      check_val("midrst_cfg", {24'd0, a_cfg}, 64'd0);
      check_val("midrst_loaded", {63'd0, a_loaded}, 64'd0);
      check_val("midrst_busy", {63'd0, a_busy}, 64'd0);
      check_val("midrst_b_cfg", {34'd0, b_cfg}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      load_fq5(40'hCAFEF00D42);
      send_frame(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D ^ 8'h42, 0);

      // Randomized frames against the model.
      for (int f = 0; f < 40; f++) begin
         logic [7:0] x;
         cur_sel = ($urandom_range(0, 3) == 0);
         nb = nbytes_of(cur_sel);
         for (int gi = 0; gi < int'($urandom_range(0, 2)); gi++) begin
            g = 8'($urandom());
            if (g == 8'hA5) g = 8'h5A;
            send_garbage(g);
         end
         fq.delete();
         x = 8'h00;
         for (int j = 0; j < nb; j++) begin
            fq.push_back(8'($urandom()));
            x = x ^ fq[j];
         end
         if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
         send_frame(x, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
